dsk_mem_arbiter: RTL and testbench

DSK_MEM_ARBITER -- requirements
Module: dsk_mem_arbiter

---
 rtl/dsk_pkg.sv | 6 +
 rtl/dsk_vmap.sv | 25 ++
 rtl/dsk_mem_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_dsk_mem_arbiter.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/dsk_pkg.sv
// dsk_pkg: shared arbiter state encoding and default parameters
package dsk_pkg;
  typedef enum logic [2:0] {IDLE, GRANT_DSK, GRANT_CPU, WAIT_DSK, WAIT_CPU} arb_state_e;
  localparam int          STARVE_MAX_DEF = 4;
  localparam logic [24:0] ROM_BASE_DEF   = 25'h0F0000;
endpackage

// File: rtl/dsk_vmap.sv
// dsk_vmap: disk-copy virtual to physical address translation (combinational)
//   virt_i      : 1 = translate addr_i[15:0] through the page windows
//   addr_i      : disk-copy address
//   page_w1_i/2 : page numbers for windows 040000 / 0100000
//   paddr_o     : physical address
//   rom_o       : address falls in the read-only ROM window
module dsk_vmap import dsk_pkg::*; #(
  parameter logic [24:0] ROM_BASE = ROM_BASE_DEF
) (
  input  logic        virt_i,
  input  logic [24:0] addr_i,
  input  logic [2:0]  page_w1_i,
  input  logic [2:0]  page_w2_i,
  output logic [24:0] paddr_o,
  output logic        rom_o
);
  logic [24:0] off;
  assign off = {11'd0, addr_i[13:0]};
  assign rom_o = virt_i & (addr_i[15:14] == 2'b11);
  assign paddr_o = !virt_i                  ? addr_i :
                   addr_i[15:14] == 2'b00   ? {9'd0, addr_i[15:0]} :
                   addr_i[15:14] == 2'b01   ? {8'd0, page_w1_i, 14'd0} + off :
                   addr_i[15:14] == 2'b10   ? {8'd0, page_w2_i, 14'd0} + off :
                                              ROM_BASE + off;
endmodule

// File: rtl/dsk_mem_arbiter.sv
// dsk_mem_arbiter: arbitrates one memory port between the CPU and a disk-copy engine
//   clk_sys/reset : system clock, synchronous active-high reset
//   ce_bus        : bus clock enable, only used to time disk accesses
//   cpu_*         : level CPU request, one-cycle cpu_ack on completion
//   dsk_copy_*    : edge-triggered disk requests, dsk_wait while outstanding
//   mem_*         : memory port, mem_rd/mem_we held until mem_ready pulse
module dsk_mem_arbiter import dsk_pkg::*; #(
  parameter int          STARVE_MAX = STARVE_MAX_DEF,
  parameter logic [24:0] ROM_BASE   = ROM_BASE_DEF
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ce_bus,
  input  logic [2:0]  page_w1,
  input  logic [2:0]  page_w2,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [1:0]  cpu_wtbt,
  input  logic [24:0] cpu_addr,
  input  logic [15:0] cpu_dout,
  output logic [15:0] cpu_din,
  output logic        cpu_ack,
  input  logic        dsk_copy,
  input  logic        dsk_copy_virt,
  input  logic        dsk_copy_rd,
  input  logic        dsk_copy_we,
  input  logic [24:0] dsk_copy_addr,
  input  logic [15:0] dsk_copy_dout,
  output logic [15:0] dsk_copy_din,
  output logic        dsk_wait,
  output logic        mem_rd,
  output logic        mem_we,
  output logic [1:0]  mem_be,
  output logic [24:0] mem_addr,
  output logic [15:0] mem_dout,
  input  logic [15:0] mem_din,
  input  logic        mem_ready
);
  localparam logic [24:0] ADDR_MASK = 25'h1FFFFFE;
  arb_state_e  state_q, state_d;
  logic        pend_q, pend_d, p_we_q, p_we_d, p_virt_q, p_virt_d;
  logic [24:0] p_addr_q, p_addr_d, mem_addr_q, mem_addr_d, vaddr;
  logic [15:0] p_dout_q, p_dout_d, mem_dout_q, mem_dout_d;
  logic [15:0] cpu_din_q, cpu_din_d, dsk_din_q, dsk_din_d;
  logic        rd_prev_q, we_prev_q, copy_prev_q;
  logic [2:0]  starve_q, starve_d;
  logic        ack_q, ack_d, mem_rd_q, mem_rd_d, mem_we_q, mem_we_d, drop_q, drop_d;
  logic [1:0]  mem_be_q, mem_be_d, ce_cnt_q, ce_cnt_d;
  logic        late_q, late_d;
  logic        rom_hit, rd_rise, we_rise, dsk_edge, cancel, cpu_ok, in_dsk, dsk_go;

  dsk_vmap #(.ROM_BASE(ROM_BASE)) u_vmap (
    .virt_i(p_virt_q), .addr_i(p_addr_q), .page_w1_i(page_w1), .page_w2_i(page_w2),
    .paddr_o(vaddr), .rom_o(rom_hit)
  );

  assign rd_rise  = dsk_copy_rd & ~rd_prev_q;
  assign we_rise  = dsk_copy_we & ~we_prev_q;
  assign dsk_edge = dsk_copy & (rd_rise | we_rise);
  assign in_dsk   = (state_q == GRANT_DSK) | (state_q == WAIT_DSK);
  // a session ending only cancels work that has not yet reached the memory
  assign cancel   = copy_prev_q & ~dsk_copy & ~in_dsk;
  // the cycle after an ack the CPU has not yet had a chance to drop its request
  assign cpu_ok   = cpu_req & ~ack_q;
  assign dsk_go   = pend_q & ~cancel & ((starve_q < 3'(STARVE_MAX)) | ~cpu_ok);

  assign dsk_wait     = pend_q | in_dsk;
  assign cpu_ack      = ack_q;
  assign cpu_din      = cpu_din_q;
  assign dsk_copy_din = dsk_din_q;
  assign mem_rd       = mem_rd_q;
  assign mem_we       = mem_we_q;
  assign mem_be       = mem_be_q;
  assign mem_addr     = mem_addr_q;
  assign mem_dout     = mem_dout_q;

  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    p_we_d     = p_we_q;
    p_virt_d   = p_virt_q;
    p_addr_d   = p_addr_q;
    p_dout_d   = p_dout_q;
    starve_d   = starve_q;
    ack_d      = 1'b0;
    mem_rd_d   = mem_rd_q;
    mem_we_d   = mem_we_q;
    mem_be_d   = mem_be_q;
    mem_addr_d = mem_addr_q;
    mem_dout_d = mem_dout_q;
    cpu_din_d  = cpu_din_q;
    dsk_din_d  = dsk_din_q;
    drop_d     = drop_q;
    case (state_q)
      IDLE:
        if (dsk_go) begin
          state_d    = GRANT_DSK;
          pend_d     = 1'b0;
          drop_d     = p_we_q & rom_hit;
          mem_rd_d   = ~p_we_q;
          mem_we_d   = p_we_q & ~rom_hit;
          mem_be_d   = 2'b11;
          mem_addr_d = vaddr & ADDR_MASK;
          mem_dout_d = p_dout_q;
          starve_d   = (cpu_ok && starve_q < 3'(STARVE_MAX)) ? starve_q + 3'd1 : starve_q;
        end else if (cpu_ok) begin
          state_d    = GRANT_CPU;
          mem_rd_d   = ~cpu_we;
          mem_we_d   = cpu_we;
          mem_be_d   = cpu_we ? cpu_wtbt : 2'b11;
          mem_addr_d = cpu_addr & ADDR_MASK;
          mem_dout_d = cpu_dout;
          starve_d   = 3'd0;
        end
      // a dropped ROM write never reaches memory, so finish without waiting
      GRANT_DSK: state_d = drop_q ? IDLE : WAIT_DSK;
      GRANT_CPU: state_d = WAIT_CPU;
      WAIT_DSK:
        if (mem_ready) begin
          state_d   = IDLE;
          mem_rd_d  = 1'b0;
          mem_we_d  = 1'b0;
          dsk_din_d = mem_rd_q ? mem_din : dsk_din_q;
        end
      WAIT_CPU:
        if (mem_ready) begin
          state_d   = IDLE;
          mem_rd_d  = 1'b0;
          mem_we_d  = 1'b0;
          cpu_din_d = mem_rd_q ? mem_din : cpu_din_q;
          ack_d     = 1'b1;
        end
      default: state_d = IDLE;
    endcase
    if (!cpu_ok) starve_d = 3'd0;
    if (cancel) pend_d = 1'b0;
    if (dsk_edge) begin
      pend_d   = 1'b1;
      p_we_d   = we_rise;
      p_virt_d = dsk_copy_virt;
      p_addr_d = dsk_copy_addr;
      p_dout_d = dsk_copy_dout;
    end
    ce_cnt_d = !in_dsk ? 2'd0 : (ce_bus && ce_cnt_q != 2'd3) ? ce_cnt_q + 2'd1 : ce_cnt_q;
    late_d   = late_q | (in_dsk & ce_bus & (ce_cnt_q == 2'd2));
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q     <= IDLE;
      pend_q      <= 1'b0;
      p_we_q      <= 1'b0;
      p_virt_q    <= 1'b0;
      p_addr_q    <= '0;
      p_dout_q    <= '0;
      rd_prev_q   <= 1'b0;
      we_prev_q   <= 1'b0;
      copy_prev_q <= 1'b0;
      starve_q    <= '0;
      ack_q       <= 1'b0;
      mem_rd_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= '0;
      mem_addr_q  <= '0;
      mem_dout_q  <= '0;
      cpu_din_q   <= '0;
      dsk_din_q   <= '0;
      drop_q      <= 1'b0;
      ce_cnt_q    <= '0;
      late_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      p_we_q      <= p_we_d;
      p_virt_q    <= p_virt_d;
      p_addr_q    <= p_addr_d;
      p_dout_q    <= p_dout_d;
      rd_prev_q   <= dsk_copy_rd;
      we_prev_q   <= dsk_copy_we;
      copy_prev_q <= dsk_copy;
      starve_q    <= starve_d;
      ack_q       <= ack_d;
      mem_rd_q    <= mem_rd_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_addr_q  <= mem_addr_d;
      mem_dout_q  <= mem_dout_d;
      cpu_din_q   <= cpu_din_d;
      dsk_din_q   <= dsk_din_d;
      drop_q      <= drop_d;
      ce_cnt_q    <= ce_cnt_d;
      late_q      <= late_d;
    end
  end
endmodule

// File: tb/tb_dsk_mem_arbiter.sv
// tb_dsk_mem_arbiter: directed, table-driven bench for dsk_mem_arbiter
module tb_dsk_mem_arbiter;
  logic        clk_sys = 1'b0, reset, ce_bus;
  logic [2:0]  page_w1, page_w2;
  logic        cpu_req, cpu_we, cpu_ack;
  logic [1:0]  cpu_wtbt, mem_be;
  logic [24:0] cpu_addr, dsk_copy_addr, mem_addr;
  logic [15:0] cpu_dout, cpu_din, dsk_copy_dout, dsk_copy_din, mem_dout, mem_din;
  logic        dsk_copy, dsk_copy_virt, dsk_copy_rd, dsk_copy_we, dsk_wait;
  logic        mem_rd, mem_we, mem_ready;
  int          n_chk = 0, n_fail = 0;

  localparam logic [24:0] CPU_A = 25'h0AA000;

  typedef struct {
    logic        virt, rd, we;
    logic [24:0] addr;
    logic [2:0]  pw1, pw2;
    logic [15:0] dout, din;
    logic        e_rd, e_we;
    logic [24:0] e_addr;
    logic [15:0] e_din;
  } vec_t;
  vec_t vt[8];

  dsk_mem_arbiter dut (
    .clk_sys(clk_sys), .reset(reset), .ce_bus(ce_bus), .page_w1(page_w1), .page_w2(page_w2),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_wtbt(cpu_wtbt), .cpu_addr(cpu_addr),
    .cpu_dout(cpu_dout), .cpu_din(cpu_din), .cpu_ack(cpu_ack),
    .dsk_copy(dsk_copy), .dsk_copy_virt(dsk_copy_virt), .dsk_copy_rd(dsk_copy_rd),
    .dsk_copy_we(dsk_copy_we), .dsk_copy_addr(dsk_copy_addr), .dsk_copy_dout(dsk_copy_dout),
    .dsk_copy_din(dsk_copy_din), .dsk_wait(dsk_wait),
    .mem_rd(mem_rd), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_dout(mem_dout), .mem_din(mem_din), .mem_ready(mem_ready)
  );

  always #5 clk_sys = ~clk_sys;

  initial begin
    ce_bus = 1'b0;
    for (int k = 0; ; k++) begin
      @(posedge clk_sys);
      #1 ce_bus = (k % 4 == 0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick;
    @(posedge clk_sys);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_grant;
    for (int i = 0; i < 10 && !(mem_rd || mem_we); i++) tick;
    check("grant_timeout", {31'd0, mem_rd | mem_we}, 32'd1);
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    v = vt[i];
    page_w1 = v.pw1; page_w2 = v.pw2; dsk_copy = 1'b1;
    dsk_copy_virt = v.virt; dsk_copy_addr = v.addr; dsk_copy_dout = v.dout;
    dsk_copy_rd = v.rd; dsk_copy_we = v.we;
    tick;
    dsk_copy_rd = 1'b0; dsk_copy_we = 1'b0;
    check($sformatf("v%0d_pend_wait", i), {31'd0, dsk_wait}, 32'd1);
    tick;
    check($sformatf("v%0d_rd", i), {31'd0, mem_rd}, {31'd0, v.e_rd});
    check($sformatf("v%0d_we", i), {31'd0, mem_we}, {31'd0, v.e_we});
    if (v.e_rd || v.e_we) begin
      check($sformatf("v%0d_addr", i), {7'd0, mem_addr}, {7'd0, v.e_addr});
      check($sformatf("v%0d_be", i), {30'd0, mem_be}, 32'd3);
      if (v.e_we) check($sformatf("v%0d_dout", i), {16'd0, mem_dout}, {16'd0, v.dout});
      tick;
      check($sformatf("v%0d_hold", i), {31'd0, mem_rd | mem_we}, 32'd1);
      mem_ready = 1'b1; mem_din = v.din;
      tick;
      mem_ready = 1'b0;
      check($sformatf("v%0d_drop", i), {31'd0, mem_rd | mem_we}, 32'd0);
    end else begin
      tick;
    end
    check($sformatf("v%0d_wait_low", i), {31'd0, dsk_wait}, 32'd0);
    check($sformatf("v%0d_din", i), {16'd0, dsk_copy_din}, {16'd0, v.e_din});
  endtask

  initial begin
    int g[16];
    int ng, nd, acks, cpos, ndsk;
    vt[0] = '{1'b1, 1'b1, 1'b0, 25'h0004010, 3'd3, 3'd0, 16'h0000, 16'hBEEF, 1'b1, 1'b0, 25'h000C010, 16'hBEEF};
    vt[1] = '{1'b1, 1'b1, 1'b0, 25'h0008123, 3'd3, 3'd5, 16'h0000, 16'h1234, 1'b1, 1'b0, 25'h0014122, 16'h1234};
    vt[2] = '{1'b1, 1'b1, 1'b0, 25'h1FF2346, 3'd3, 3'd5, 16'h0000, 16'h5555, 1'b1, 1'b0, 25'h0002346, 16'h5555};
    vt[3] = '{1'b1, 1'b1, 1'b0, 25'h000C100, 3'd3, 3'd5, 16'h0000, 16'hAAAA, 1'b1, 1'b0, 25'h00F0100, 16'hAAAA};
    vt[4] = '{1'b1, 1'b0, 1'b1, 25'h000E000, 3'd3, 3'd5, 16'h1111, 16'hFFFF, 1'b0, 1'b0, 25'h0000000, 16'hAAAA};
    vt[5] = '{1'b0, 1'b1, 1'b1, 25'h0120001, 3'd3, 3'd5, 16'h7E57, 16'hFFFF, 1'b0, 1'b1, 25'h0120000, 16'hAAAA};
    vt[6] = '{1'b1, 1'b0, 1'b1, 25'h0007FFF, 3'd7, 3'd5, 16'h0F0F, 16'hFFFF, 1'b0, 1'b1, 25'h001FFFE, 16'hAAAA};
    vt[7] = '{1'b0, 1'b1, 1'b0, 25'h1FFFFFF, 3'd7, 3'd5, 16'h0000, 16'hC3C3, 1'b1, 1'b0, 25'h1FFFFFE, 16'hC3C3};

    reset = 1'b1; page_w1 = '0; page_w2 = '0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_wtbt = 2'b11; cpu_addr = '0; cpu_dout = '0;
    dsk_copy = 1'b0; dsk_copy_virt = 1'b0; dsk_copy_rd = 1'b0; dsk_copy_we = 1'b0;
    dsk_copy_addr = '0; dsk_copy_dout = '0; mem_din = '0; mem_ready = 1'b0;
    repeat (3) tick;
    reset = 1'b0;
    check("rst_ctrl", {26'd0, mem_rd, mem_we, cpu_ack, dsk_wait, mem_be}, 32'd0);
    check("rst_addr", {7'd0, mem_addr}, 32'd0);
    check("rst_dout", {16'd0, mem_dout}, 32'd0);
    check("rst_din", {cpu_din, dsk_copy_din}, 32'd0);

    for (int i = 0; i < 8; i++) run_vec(i);

    // CPU byte write
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_wtbt = 2'b10; cpu_addr = 25'h000101; cpu_dout = 16'hA5A5;
    wait_grant;
    check("cw_we", {31'd0, mem_we}, 32'd1);
    check("cw_be", {30'd0, mem_be}, 32'd2);
    check("cw_dout", {16'd0, mem_dout}, 32'h0000A5A5);
    check("cw_addr", {7'd0, mem_addr}, 32'h00000100);
    tick;
    mem_ready = 1'b1;
    tick;
    mem_ready = 1'b0;
    acks = cpu_ack ? 1 : 0;
    if (cpu_ack) cpu_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick;
      if (cpu_ack) acks++;
      cpu_req = 1'b0;
    end
    check("cw_acks", acks, 32'd1);
    check("cw_din_hold", {16'd0, cpu_din}, 32'd0);

    // CPU read, request held through the ack cycle must not be re-granted
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_wtbt = 2'b01; cpu_addr = 25'h0AA003;
    tick;
    check("cr_rd", {31'd0, mem_rd}, 32'd1);
    check("cr_be", {30'd0, mem_be}, 32'd3);
    check("cr_addr", {7'd0, mem_addr}, 32'h000AA002);
    tick;
    mem_ready = 1'b1; mem_din = 16'h1357;
    tick;
    mem_ready = 1'b0;
    check("cr_ack", {31'd0, cpu_ack}, 32'd1);
    check("cr_din", {16'd0, cpu_din}, 32'h00001357);
    tick;
    check("cr_ack_once", {31'd0, cpu_ack}, 32'd0);
    check("cr_no_regrant", {31'd0, mem_rd | mem_we}, 32'd0);
    cpu_req = 1'b0;
    tick;

    // starvation: CPU held while disk requests keep arriving back to back
    cpu_addr = CPU_A; cpu_we = 1'b0;
    dsk_copy_virt = 1'b0; dsk_copy_addr = 25'h000200; mem_din = 16'h0202;
    ng = 0; nd = 1; acks = 0;
    dsk_copy_rd = 1'b1;
    tick;
    dsk_copy_rd = 1'b0; cpu_req = 1'b1;
    for (int c = 0; c < 100 && ng < 7; c++) begin
      tick;
      if (cpu_ack) begin acks++; cpu_req = 1'b0; end
      if (mem_rd) begin
        g[ng] = (mem_addr == CPU_A) ? 1 : 0;
        if (g[ng] == 0 && nd < 6) begin dsk_copy_rd = 1'b1; nd++; end
        ng++;
        tick;
        dsk_copy_rd = 1'b0; mem_ready = 1'b1;
        tick;
        mem_ready = 1'b0;
        if (cpu_ack) begin acks++; cpu_req = 1'b0; end
      end
    end
    cpos = -1; ndsk = 0;
    for (int i = 0; i < ng; i++) begin
      if (g[i] == 1 && cpos < 0) cpos = i;
      if (g[i] == 0) ndsk++;
    end
    check("st_grants", ng, 32'd7);
    check("st_cpu_pos", cpos, 32'd4);
    check("st_dsk_grants", ndsk, 32'd6);
    check("st_acks", acks, 32'd1);
    tick;
    check("st_idle", {30'd0, dsk_wait, mem_rd}, 32'd0);

    // session end cancels a pending disk request, CPU access still completes
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = CPU_A;
    tick;
    dsk_copy_rd = 1'b1;
    tick;
    dsk_copy_rd = 1'b0; dsk_copy = 1'b0;
    check("cn_pend", {31'd0, dsk_wait}, 32'd1);
    tick;
    check("cn_cancel", {31'd0, dsk_wait}, 32'd0);
    mem_ready = 1'b1; mem_din = 16'h4444;
    tick;
    mem_ready = 1'b0; cpu_req = 1'b0;
    check("cn_ack", {31'd0, cpu_ack}, 32'd1);
    repeat (2) tick;
    check("cn_no_dsk", {30'd0, mem_rd, dsk_wait}, 32'd0);

    // reset in WAIT_DSK, late mem_ready ignored
    dsk_copy = 1'b1; dsk_copy_addr = 25'h000300; dsk_copy_rd = 1'b1;
    tick;
    dsk_copy_rd = 1'b0;
    tick;
    check("rm_grant", {31'd0, mem_rd}, 32'd1);
    tick;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    check("rm_ctrl", {26'd0, mem_rd, mem_we, cpu_ack, dsk_wait, mem_be}, 32'd0);
    check("rm_addr", {7'd0, mem_addr}, 32'd0);
    check("rm_dout", {16'd0, mem_dout}, 32'd0);
    tick;
    mem_ready = 1'b1; mem_din = 16'hDEAD;
    tick;
    mem_ready = 1'b0;
    check("rm_din", {cpu_din, dsk_copy_din}, 32'd0);
    tick;
    check("rm_idle", {29'd0, mem_rd, mem_we, dsk_wait}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
